mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester may own the mux (legal 1..15).
REQ-002 Port: clk  input  1  single clock, rising-edge active.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per source; bit i = source i (0=a, 1=b, 2=c, 3=d).
REQ-005 Port: din  input  4  data bits of sources a..d (din[0]=a ... din[3]=d).
REQ-006 Port: grant  output  4  one-hot owner of the mux; 0000 when idle.
REQ-007 Port: select  output  2  mux select, binary index of the current owner.
REQ-008 Port: busy  output  1  high while any grant is active.
REQ-009 Port: dout  output  1  registered mux output.
REQ-010 Port: dout_valid  output  1  dout holds data of a granted source.

Function
REQ-011 The design SHALL use two states: IDLE (grant=0000, busy=0) and OWN (grant one-hot, busy=1).
REQ-012 Round-robin pointer ptr[1:0] = last released owner; the search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4, wrapping 3->0).
REQ-013 IDLE: if req!=0 at edge k, the design SHALL enter OWN at edge k with grant=winner, select=winner index, hold_cnt=0; otherwise it SHALL stay in IDLE.
REQ-014 OWN: hold_cnt SHALL increment each cycle; release occurs when req[owner]==0 or hold_cnt==MAX_HOLD-1.
REQ-015 On release the design SHALL set ptr<=owner and re-arbitrate in the same cycle: if a winner exists (the owner included, at lowest priority), it SHALL grant that winner at the same edge with no idle bubble and hold_cnt=0; otherwise it SHALL enter IDLE.
REQ-016 A sole continuous requester SHALL be re-granted every MAX_HOLD cycles; grant stays unchanged and does not glitch to 0000.
REQ-017 select SHALL hold its last value while IDLE.
REQ-018 Every cycle, dout SHALL load the mux output for the current select, and dout_valid SHALL load busy: one cycle of latency from grant to dout.
REQ-019 Request changes from non-owners SHALL have no effect until the next release.
REQ-020 grant SHALL never have more than one bit set.

Reset
REQ-021 While rst_n=0, the following SHALL hold immediately, independent of clk: state=IDLE, grant=0000, select=00, busy=0, dout=0, dout_valid=0, hold_cnt=0, ptr=3.
REQ-022 Reset asserted mid-grant SHALL abort the grant immediately; after rst_n rises, the first arbitration SHALL favour source 0.
REQ-023 No output SHALL change on the clock edge that coincides with rst_n=0.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE, OWN), the requester count (4), and the select width (2).
REQ-025 The design SHALL contain exactly one sub-module: the existing 4:1 mux (ports a, b, c, d, select, out), fed from din and select.
REQ-026 All sequential logic, including the arbiter, counter and output registers, SHALL reside in mux_arbiter.

Verification
REQ-027 Reset: hold rst_n=0 with req=1111 -> grant=0000, select=00, busy=0, dout=0, dout_valid=0.
REQ-028 Single requester: req=0100 for 10 cycles, din=0100 (c=1) -> grant=0100 and select=10 after the first edge; grant constant for all 10 cycles; dout=1 with dout_valid=1 from the second edge.
REQ-029 Rotation: MAX_HOLD=4, req=1111 constant -> grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
REQ-030 Early release: req=0011; drop req[0] after 2 grant cycles -> grant switches 0001->0010 on the next edge with busy continuously 1.
REQ-031 Drain: a single owner deasserts req with no other requests -> grant=0000 and busy=0 at the next edge; select unchanged; dout_valid=0 one edge later.
REQ-032 Mid-grant reset: pulse rst_n low between edges while grant=1000 -> outputs clear without a clock edge; with req=1001 after release, the first grant is 0001.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count and select/counter widths.
package mux_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

endpackage : mux_arbiter_pkg

// File: rtl/mux_arbiter_mux4.sv
// Plain combinational 4:1 bit multiplexer steered by a binary select.
module mux_arbiter_mux4
  import mux_arbiter_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic [SEL_W-1:0] select,
  output logic             out
);

  always_comb begin
    case (select)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule : mux_arbiter_mux4

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning a 4:1 mux: bounded tenure per owner, same-edge
// re-arbitration on release, and a registered mux output with valid flag.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_select;
  logic [SEL_W-1:0]    r_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_dout;
  logic                r_dout_valid;

  state_t              w_state_nxt;
  logic [SEL_W-1:0]    w_select_nxt;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_release;
  logic [SEL_W-1:0]    w_base;
  logic [SEL_W-1:0]    w_idx;
  logic [SEL_W-1:0]    w_winner;
  logic                w_found;
  logic                w_mux_out;

  mux_arbiter_mux4 u_mux (
    .a      (din[0]),
    .b      (din[1]),
    .c      (din[2]),
    .d      (din[3]),
    .select (r_select),
    .out    (w_mux_out)
  );

  // Search starts after the base (last owner or pointer); scanning from the
  // lowest priority upward lets the highest-priority hit overwrite the rest.
  always_comb begin
    w_release = (r_state == ST_OWN) &&
                (!req[r_select] || (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)));
    w_base    = (r_state == ST_OWN) ? r_select : r_ptr;
    w_found   = 1'b0;
    w_winner  = w_base;
    w_idx     = w_base;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = w_base + SEL_W'(k);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_OWN;
          w_select_nxt = w_winner;
          w_hold_nxt   = '0;
        end
      end
      ST_OWN: begin
        if (w_release) begin
          w_ptr_nxt  = r_select;
          w_hold_nxt = '0;
          if (w_found) begin
            w_select_nxt = w_winner;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_select     <= '0;
      r_ptr        <= SEL_W'(N_REQ - 1);
      r_hold_cnt   <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_select     <= w_select_nxt;
      r_ptr        <= w_ptr_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_dout       <= w_mux_out;
      r_dout_valid <= (r_state == ST_OWN);
    end
  end

  assign busy       = (r_state == ST_OWN);
  assign grant      = busy ? (N_REQ'(1) << r_select) : '0;
  assign select     = r_select;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// Directed plus randomized bench for mux_arbiter, checked against a
// tenure-counting round-robin model kept in plain integers.
module tb_mux_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       dout;
  logic       dout_valid;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: owner index (-1 when idle) and cycles owned so far.
  int   m_owner;
  int   m_tenure;
  int   m_ptr;
  int   m_sel;
  logic m_dout;
  logic m_dv;

  mux_arbiter #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .grant      (grant),
    .select     (select),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (ptr + i) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_ptr    = 3;
    m_sel    = 0;
    m_dout   = 1'b0;
    m_dv     = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
    m_dout = d[m_sel];
    m_dv   = (m_owner >= 0);
    if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner  = pick(m_ptr, r);
        m_tenure = 1;
        m_sel    = m_owner;
      end
    end else if (!r[m_owner] || m_tenure == MH) begin
      m_ptr   = m_owner;
      m_owner = pick(m_ptr, r);
      if (m_owner >= 0) begin
        m_tenure = 1;
        m_sel    = m_owner;
      end
    end else begin
      m_tenure++;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".grant"}, grant, (m_owner < 0) ? 4'b0 : (4'b1 << m_owner));
    check({tag, ".select"}, {2'b0, select}, 4'(m_sel));
    check({tag, ".busy"}, {3'b0, busy}, {3'b0, (m_owner >= 0)});
    check({tag, ".dout"}, {3'b0, dout}, {3'b0, m_dout});
    check({tag, ".dout_valid"}, {3'b0, dout_valid}, {3'b0, m_dv});
    check({tag, ".onehot"}, {3'b0, ($countones(grant) <= 1)}, 4'b0001);
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    step("rst_edge", 4'b1111, 4'b1111);
    rst_n = 1'b1;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b1111;
    din   = 4'b0000;
    model_reset();
    #2;

    // Reset with all requesters active; an edge during reset changes nothing.
    apply_reset();
    step("rst_hold", 4'b1111, 4'b1010);
    rst_n = 1'b0;
    step("rst_hold2", 4'b1111, 4'b1010);
    check("rst_grant_zero", grant, 4'b0000);
    rst_n = 1'b1;

    // Single requester c with c data high.
    for (int i = 0; i < 10; i++) begin
      step("single_c", 4'b0100, 4'b0100);
      check("single_c_grant", grant, 4'b0100);
      if (i > 0) check("single_c_dout", {2'b0, dout_valid, dout}, 4'b0011);
    end

    // Drain: owner drops, nobody else asks.
    step("drain", 4'b0000, 4'b0100);
    check("drain_select", {2'b0, select}, 4'b0010);
    step("drain2", 4'b0000, 4'b0100);

    // Rotation with all four requesting.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step("rotate", 4'b1111, 4'($urandom_range(0, 15)));
      check("rotate_seq", grant, 4'b1 << ((i / MH) % 4));
    end

    // Early release of a after two grant cycles.
    apply_reset();
    step("early", 4'b0011, 4'b0001);
    step("early", 4'b0011, 4'b0001);
    check("early_a", grant, 4'b0001);
    step("early_sw", 4'b0010, 4'b0010);
    check("early_b", {busy, 3'b0} | grant, 4'b1010);

    // Mid-grant asynchronous reset while d owns the mux.
    apply_reset();
    step("own_d", 4'b1000, 4'b1000);
    step("own_d", 4'b1000, 4'b1000);
    check("own_d_grant", grant, 4'b1000);
    pulse_reset("midrst");
    step("after_rst", 4'b1001, 4'b0001);
    check("after_rst_grant", grant, 4'b0001);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step("rand", r, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 79) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mux_arbiter
